idct_skew_feeder: RTL and testbench

//  Upstream feeder for the 4-point IDCT multiply-accumulate row stage. Collects serial
//  16-bit coefficients into groups of 4 and launches each group onto d_in_1..d_in_4.

---
 rtl/idct_pkg.sv | 16 +
 rtl/idct_delay_line.sv | 25 ++
 rtl/idct_skew_feeder.sv | 147 ++++++++++++++
 tb/tb_idct_skew_feeder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/idct_pkg.sv
// Shared constants and types for the 4-point IDCT row stage and its feeders.
package idct_pkg;

  localparam int IDCT_DW      = 16;
  localparam int IDCT_NPT     = 4;
  localparam int IDCT_ROW_LAT = 3;

  typedef logic signed [IDCT_DW-1:0] coef_t;

  typedef enum logic [1:0] {
    BOOT_HOLD = 2'd0,
    BOOT_WARM = 2'd1,
    BOOT_RUN  = 2'd2
  } boot_state_t;

endpackage

// File: rtl/idct_delay_line.sv
// Fixed-depth shift register; every stage clears to zero on async reset.
module idct_delay_line #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/idct_skew_feeder.sv
// Collects serial coefficients in groups of four and launches them onto skewed
// row-stage lanes, with a valid/tag pulse aligned to the row-stage result.
//
//  state     | meaning
//  BOOT_HOLD | first edge after reset release, not ready
//  BOOT_WARM | second edge pending, s_ready rises on it
//  BOOT_RUN  | accepting coefficients
module idct_skew_feeder
  import idct_pkg::*;
#(
  parameter int DW    = IDCT_DW,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DW-1:0]    s_data,
  output logic [DW-1:0]    d_in_1,
  output logic [DW-1:0]    d_in_2,
  output logic [DW-1:0]    d_in_3,
  output logic [DW-1:0]    d_in_4,
  output logic [3:0]       lane_vld,
  output logic             out_valid,
  output logic [TAG_W-1:0] out_tag
);

  localparam int CNT_W = $clog2(IDCT_NPT);

  boot_state_t state_q, state_d;
  logic        ready_d;

  logic [CNT_W-1:0] cnt_q;
  logic [DW-1:0]    coll_q [IDCT_NPT];
  logic [TAG_W-1:0] tag_q;

  logic             lch_vld_q;
  logic [TAG_W-1:0] lch_tag_q;
  logic [DW-1:0]    lch_data_q [IDCT_NPT];

  logic [DW:0]      lane_q [IDCT_NPT];
  logic [TAG_W:0]   out_pipe;

  logic accept;
  logic take;
  logic launch;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= BOOT_HOLD;
      s_ready <= 1'b0;
    end else begin
      state_q <= state_d;
      s_ready <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ready_d = 1'b0;
    case (state_q)
      BOOT_HOLD: state_d = BOOT_WARM;
      BOOT_WARM: begin
        state_d = BOOT_RUN;
        ready_d = 1'b1;
      end
      BOOT_RUN:  ready_d = 1'b1;
      default:   state_d = BOOT_HOLD;
    endcase
  end

  // clr wins over a coincident accept: the word is dropped and no launch occurs.
  assign accept = s_valid & s_ready;
  assign take   = accept & ~clr;
  assign launch = take & (cnt_q == CNT_W'(IDCT_NPT - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      for (int k = 0; k < IDCT_NPT; k++) coll_q[k] <= '0;
    end else if (clr) begin
      cnt_q <= '0;
      for (int k = 0; k < IDCT_NPT; k++) coll_q[k] <= '0;
    end else if (accept) begin
      coll_q[cnt_q] <= s_data;
      cnt_q         <= cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_q <= '0;
    end else if (launch) begin
      tag_q <= tag_q + TAG_W'(1);
    end
  end

  // Launch register holds the whole vector for one cycle; idle cycles load zeros
  // so the lanes behind it shift clean zeros to the accumulators.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lch_vld_q <= 1'b0;
      lch_tag_q <= '0;
      for (int k = 0; k < IDCT_NPT; k++) lch_data_q[k] <= '0;
    end else begin
      lch_vld_q <= launch;
      lch_tag_q <= launch ? tag_q : '0;
      for (int k = 0; k < IDCT_NPT - 1; k++) lch_data_q[k] <= launch ? coll_q[k] : '0;
      lch_data_q[IDCT_NPT-1] <= launch ? s_data : '0;
    end
  end

  assign lane_q[0] = {lch_vld_q, lch_data_q[0]};

  for (genvar g = 1; g < IDCT_NPT; g++) begin : g_lane
    idct_delay_line #(
      .W     (DW + 1),
      .DEPTH (g)
    ) u_lane_dly (
      .clk   (clk),
      .rst_n (reset),
      .din   ({lch_vld_q, lch_data_q[g]}),
      .dout  (lane_q[g])
    );
  end

  idct_delay_line #(
    .W     (TAG_W + 1),
    .DEPTH (IDCT_ROW_LAT)
  ) u_out_pipe (
    .clk   (clk),
    .rst_n (reset),
    .din   ({lch_vld_q, lch_tag_q}),
    .dout  (out_pipe)
  );

  assign d_in_1   = lane_q[0][DW-1:0];
  assign d_in_2   = lane_q[1][DW-1:0];
  assign d_in_3   = lane_q[2][DW-1:0];
  assign d_in_4   = lane_q[3][DW-1:0];
  assign lane_vld = {lane_q[3][DW], lane_q[2][DW], lane_q[1][DW], lane_q[0][DW]};

  assign out_valid = out_pipe[TAG_W];
  assign out_tag   = out_pipe[TAG_W-1:0];

endmodule

// File: tb/tb_idct_skew_feeder.sv
// Bench for idct_skew_feeder: cycle-indexed expectation table filled from a
// queue-based model of the collect/launch rules, plus literal spot checks.
module tb_idct_skew_feeder;

  localparam int DW    = 16;
  localparam int TAG_W = 8;
  localparam int N     = 4096;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             clr = 1'b0;
  logic             s_valid = 1'b0;
  logic [DW-1:0]    s_data = '0;
  logic             s_ready;
  logic [DW-1:0]    d_in_1, d_in_2, d_in_3, d_in_4;
  logic [3:0]       lane_vld;
  logic             out_valid;
  logic [TAG_W-1:0] out_tag;

  int n_chk  = 0;
  int n_fail = 0;

  idct_skew_feeder #(.DW(DW), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .clr       (clr),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .d_in_1    (d_in_1),
    .d_in_2    (d_in_2),
    .d_in_3    (d_in_3),
    .d_in_4    (d_in_4),
    .lane_vld  (lane_vld),
    .out_valid (out_valid),
    .out_tag   (out_tag)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: cycle k is the period after the k-th rising edge.
  int            cyc   = 0;
  int            edges = 0;
  int            tag   = 0;
  logic [DW-1:0] words [$];
  logic [DW-1:0] exp_d   [4][N];
  logic [3:0]    exp_lv  [N];
  logic          exp_ov  [N];
  logic [7:0]    exp_tag [N];

  always @(posedge clk) begin : model
    int lc;
    if (!reset) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < 4; k++) exp_d[k][i] = '0;
        exp_lv[i]  = '0;
        exp_ov[i]  = 1'b0;
        exp_tag[i] = '0;
      end
      words.delete();
      tag   = 0;
      edges = 0;
    end else begin
      if (clr) begin
        words.delete();
      end else if (s_valid && edges >= 2) begin
        words.push_back(s_data);
        if (words.size() == 4) begin
          lc = cyc + 1;
          if (lc + 3 >= N) begin
            $display("FAIL model_range: cycle %0d beyond table %0d", lc, N);
            $fatal(1, "model table overflow");
          end
          for (int k = 0; k < 4; k++) begin
            exp_d[k][lc+k]   = words[k];
            exp_lv[lc+k][k]  = 1'b1;
          end
          exp_ov[lc+3]  = 1'b1;
          exp_tag[lc+3] = 8'(tag);
          tag = (tag + 1) % 256;
          words.delete();
        end
      end
      edges++;
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (!reset) begin
      chk("rst_s_ready", 32'(s_ready), 0);
      chk("rst_lanes", {d_in_1, d_in_2}, 0);
      chk("rst_lanes34", {d_in_3, d_in_4}, 0);
      chk("rst_lane_vld", 32'(lane_vld), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_out_tag", 32'(out_tag), 0);
    end else begin
      chk("cmp_s_ready", 32'(s_ready), 32'(edges >= 2));
      chk("cmp_d_in_1", 32'(d_in_1), 32'(exp_d[0][cyc]));
      chk("cmp_d_in_2", 32'(d_in_2), 32'(exp_d[1][cyc]));
      chk("cmp_d_in_3", 32'(d_in_3), 32'(exp_d[2][cyc]));
      chk("cmp_d_in_4", 32'(d_in_4), 32'(exp_d[3][cyc]));
      chk("cmp_lane_vld", 32'(lane_vld), 32'(exp_lv[cyc]));
      chk("cmp_out_valid", 32'(out_valid), 32'(exp_ov[cyc]));
      if (exp_ov[cyc]) chk("cmp_out_tag", 32'(out_tag), 32'(exp_tag[cyc]));
    end
  end

  task automatic send(input logic [DW-1:0] w);
    s_valid = 1'b1;
    s_data  = w;
    @(negedge clk);
  endtask

  task automatic wait_ready();
    int k;
    k = 0;
    @(negedge clk);
    while (!s_ready && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("ready_timeout", 32'(s_ready), 1);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 reset = 1'b0;
    s_valid = 1'b0;
    clr     = 1'b0;
    @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    wait_ready();
  endtask

  logic [DW-1:0] w4 [4];

  initial begin
    // 1: reset with s_valid held high
    reset   = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'hDEAD;
    repeat (3) @(negedge clk);
    chk("t1_d_in_1", 32'(d_in_1), 0);
    chk("t1_s_ready", 32'(s_ready), 0);
    @(posedge clk);
    #2 reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t1_ready_edge1", 32'(s_ready), 0);
    @(negedge clk);
    chk("t1_ready_edge2", 32'(s_ready), 1);
    s_valid = 1'b0;

    // 2: single vector 1,2,3,4
    for (int i = 0; i < 4; i++) send(16'(i + 1));
    s_valid = 1'b0;
    chk("t2_d1", 32'(d_in_1), 1);
    chk("t2_lv_L", 32'(lane_vld), 32'h1);
    @(negedge clk);
    chk("t2_d2", 32'(d_in_2), 2);
    chk("t2_d1_idle", 32'(d_in_1), 0);
    @(negedge clk);
    chk("t2_d3", 32'(d_in_3), 3);
    @(negedge clk);
    chk("t2_d4", 32'(d_in_4), 4);
    chk("t2_ov", 32'(out_valid), 1);
    chk("t2_tag", 32'(out_tag), 0);
    chk("t2_lv_L3", 32'(lane_vld), 32'h8);
    @(negedge clk);
    chk("t2_ov_after", 32'(out_valid), 0);

    // 3: eight contiguous words after a fresh reset
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(16'(i + 1));
      if (i == 3) chk("t3_d1_first", 32'(d_in_1), 1);
      if (i == 6) begin
        chk("t3_ov_first", 32'(out_valid), 1);
        chk("t3_tag_first", 32'(out_tag), 0);
      end
    end
    s_valid = 1'b0;
    chk("t3_d1_second", 32'(d_in_1), 5);
    repeat (3) @(negedge clk);
    chk("t3_d4_second", 32'(d_in_4), 8);
    chk("t3_ov_second", 32'(out_valid), 1);
    chk("t3_tag_second", 32'(out_tag), 1);

    // 4: extreme values with two idle cycles between words
    w4[0] = 16'h8000;
    w4[1] = 16'h7FFF;
    w4[2] = 16'hFFFF;
    w4[3] = 16'h0000;
    for (int i = 0; i < 4; i++) begin
      send(w4[i]);
      s_valid = 1'b0;
      if (i < 3) repeat (2) @(negedge clk);
    end
    chk("t4_d1", 32'(d_in_1), 32'h8000);
    chk("t4_lv_L", 32'(lane_vld), 32'h1);
    @(negedge clk);
    chk("t4_d2", 32'(d_in_2), 32'h7FFF);
    @(negedge clk);
    chk("t4_d3", 32'(d_in_3), 32'hFFFF);
    @(negedge clk);
    chk("t4_d4", 32'(d_in_4), 0);
    chk("t4_lv_L3", 32'(lane_vld), 32'h8);
    chk("t4_tag", 32'(out_tag), 2);

    // 5: clr drops a coincident word while an earlier vector is in flight
    for (int i = 0; i < 4; i++) send(16'(11 + i));
    send(16'd21);
    send(16'd22);
    clr = 1'b1;
    send(16'd23);
    clr = 1'b0;
    chk("t5_inflight_ov", 32'(out_valid), 1);
    chk("t5_inflight_tag", 32'(out_tag), 3);
    chk("t5_inflight_d4", 32'(d_in_4), 14);
    for (int i = 0; i < 4; i++) send(16'(31 + i));
    s_valid = 1'b0;
    chk("t5_d1_after_clr", 32'(d_in_1), 31);
    repeat (3) @(negedge clk);
    chk("t5_d4_after_clr", 32'(d_in_4), 34);
    chk("t5_tag_after_clr", 32'(out_tag), 4);

    // 6: reset between L+1 and L+2, then tag wrap
    for (int i = 0; i < 4; i++) send(16'(41 + i));
    s_valid = 1'b0;
    @(negedge clk);
    chk("t6_d2_before", 32'(d_in_2), 42);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("t6_async_lv", 32'(lane_vld), 0);
    chk("t6_async_d3", 32'(d_in_3), 0);
    chk("t6_async_ready", 32'(s_ready), 0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    wait_ready();
    for (int v = 0; v < 257; v++) begin
      for (int i = 0; i < 4; i++) begin
        send(16'(v * 4 + i));
        if (v == 1 && i == 2) begin
          chk("t6_restart_ov", 32'(out_valid), 1);
          chk("t6_restart_tag", 32'(out_tag), 0);
        end
        if (v == 256 && i == 2) chk("t6_tag_255", 32'(out_tag), 255);
      end
    end
    s_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("t6_wrap_ov", 32'(out_valid), 1);
    chk("t6_wrap_tag", 32'(out_tag), 0);
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
